// File: rtl/base_fsm.sv
// base_fsm: serial read master for an 8-bit SPI-style slave.
// A one-cycle start request runs one read frame:
//   - cs_n is driven low and the frame runs SETUP -> SHIFT -> HOLD.
//   - NBITS sclk_n periods are produced, each 2*D clk cycles long.
//   - The frame ends with a one-cycle done strobe (just_test), and
//     just_test_bus is updated with the received byte.
// Every phase lasts D = clk_scaler+1 cycles. D is captured when start is accepted.
// All outputs are registered.
// Optional macro BASE_FSM_LSB_FIRST_EN: shift right so that the first received
// bit lands in bit 0. When it is undefined, data is taken MSB first.
module base_fsm #(
  parameter int W     = 8,
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     clk_scaler,
  input  logic             from_device,
  output logic             sclk_n,
  output logic             cs_n,
  output logic             just_test,
  output logic [NBITS-1:0] just_test_bus
);

  localparam int BW = $clog2(NBITS);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     cnt;        // divider counter, 0..D-1
  logic [W-1:0]     d_m1;       // captured clk_scaler (D-1)
  logic [BW-1:0]    bit_cnt;    // bit index within SHIFT
  logic             phase_hi;   // 0: sclk_n low half, 1: high half
  logic             phase_nxt;
  logic [NBITS-1:0] shreg;
  logic             tc;         // last cycle of the current D-cycle phase

  logic             sclk_n_nxt, cs_n_nxt, just_test_nxt;
  logic [NBITS-1:0] bus_nxt;

  assign tc = (cnt == d_m1);

  // State register plus the datapath and the registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      d_m1          <= '0;
      bit_cnt       <= '0;
      phase_hi      <= 1'b0;
      shreg         <= '0;
      sclk_n        <= 1'b1;
      cs_n          <= 1'b1;
      just_test     <= 1'b0;
      just_test_bus <= '0;
    end else begin
      state         <= state_nxt;
      phase_hi      <= phase_nxt;
      sclk_n        <= sclk_n_nxt;
      cs_n          <= cs_n_nxt;
      just_test     <= just_test_nxt;
      just_test_bus <= bus_nxt;

      // The divider restarts at each phase boundary and stays idle outside a frame
      if (state == IDLE || state == DONE || tc) cnt <= '0;
      else                                      cnt <= cnt + W'(1);

      // Frame setup: the divider value is frozen here for the whole frame
      if (state == IDLE) begin
        bit_cnt <= '0;
        if (start) d_m1 <= clk_scaler;
      end

      // Sample on the edge where sclk_n rises, which is the end of a low half
      if (state == SHIFT && !phase_hi && tc) begin
`ifdef BASE_FSM_LSB_FIRST_EN
        shreg <= {from_device, shreg[NBITS-1:1]};
`else
        shreg <= {shreg[NBITS-2:0], from_device};
`endif
      end

      // Advance to the next bit at the end of each high half
      if (state == SHIFT && phase_hi && tc) bit_cnt <= bit_cnt + BW'(1);
    end
  end

  // Next-state and sclk phase logic
  always_comb begin
    state_nxt = state;
    phase_nxt = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SETUP;
      SETUP: if (tc)    state_nxt = SHIFT;
      SHIFT: begin
        phase_nxt = tc ? ~phase_hi : phase_hi;
        if (tc && phase_hi && bit_cnt == BW'(NBITS-1)) state_nxt = HOLD;
      end
      HOLD:  if (tc)    state_nxt = DONE;
      DONE:             state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    cs_n_nxt      = (state_nxt == IDLE) || (state_nxt == DONE);
    sclk_n_nxt    = !((state_nxt == SHIFT) && !phase_nxt);
    just_test_nxt = (state_nxt == DONE);
    bus_nxt       = (state_nxt == DONE) ? shreg : just_test_bus;
  end

endmodule

// File: tb/tb_base_fsm.sv
// Bench for base_fsm. It uses directed frames and random back-to-back frames.
// The reference model works only from the pins:
//   - frame timing is counted in whole D-cycle phases;
//   - the expected byte is rebuilt from the from_device values present at
//     each sclk_n rising edge.
module tb_base_fsm;

  logic       clk = 1'b0;
  logic       rst, start, from_device;
  logic [7:0] clk_scaler;
  logic       sclk_n, cs_n, just_test;
  logic [7:0] just_test_bus;

  int n_assert = 0;
  int n_fail   = 0;

  base_fsm #(.W(8), .NBITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .clk_scaler(clk_scaler),
    .from_device(from_device), .sclk_n(sclk_n), .cs_n(cs_n),
    .just_test(just_test), .just_test_bus(just_test_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Expected bus value for a byte that is sent first-bit-first as tx[7]..tx[0]
  function automatic logic [7:0] bus_of(input logic [7:0] tx);
`ifdef BASE_FSM_LSB_FIRST_EN
    return rev8(tx);
`else
    return tx;
`endif
  endfunction

  logic [7:0] last_rx;

  // Preconditions for run_frame:
  //   - start is already high;
  //   - the DUT is in IDLE, so the next posedge accepts the frame.
  // The task samples on negedges, n = 1 .. 18*d+2, where sample n follows
  // accept edge + (n-1).
  // from_device changes after each sclk_n falling edge. With noise=1 it is
  // also scrambled during the high halves, where it must not be sampled.
  task automatic run_frame(input string tag, input int d, input logic [7:0] tx,
                           input bit hold, input bit disturb, input bit noise);
    int cs_low, sclk_low, falls, rises, strobes, strobe_at;
    logic prev_sclk;
    logic [7:0] rx;
    cs_low = 0; sclk_low = 0; falls = 0; rises = 0; strobes = 0; strobe_at = 0;
    prev_sclk = 1'b1; rx = '0;
    from_device = tx[7];
    @(posedge clk);
    for (int n = 1; n <= 18*d + 2; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = hold;
        chk({tag, "_cs_fall"}, cs_n, 1'b0);
      end
      if (disturb && n == 20) begin start = 1'b1; clk_scaler = 8'd2; end
      if (disturb && n == 21) start = 1'b0;
      if (!cs_n)   cs_low++;
      if (!sclk_n) sclk_low++;
      if (just_test) begin strobes++; strobe_at = n; end
      if (prev_sclk && !sclk_n) begin
        falls++;
        if (falls <= 8) from_device = tx[8-falls];
      end else if (!prev_sclk && sclk_n) begin
        rises++;
        rx = {rx[6:0], from_device};
        if (noise) from_device = 1'($urandom);
      end
      prev_sclk = sclk_n;
    end
    last_rx = rx;
    chk({tag, "_cs_low"},   cs_low,    18*d);
    chk({tag, "_sclk_low"}, sclk_low,  8*d);
    chk({tag, "_falls"},    falls,     8);
    chk({tag, "_rises"},    rises,     8);
    chk({tag, "_strobes"},  strobes,   1);
    chk({tag, "_strobe_t"}, strobe_at, 18*d + 1);
    chk({tag, "_bus"},      just_test_bus, bus_of(rx));
  endtask

  initial begin
    int bad, d, ns;
    logic [7:0] tx;
    rst = 1'b1; start = 1'b0; from_device = 1'b0; clk_scaler = 8'd0;

    // 1. reset, then stay idle with start low
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk_n, 1'b1);
    chk("rst_jt",   just_test, 1'b0);
    chk("rst_bus",  just_test_bus, 8'h00);
    rst = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (!cs_n || !sclk_n || just_test || just_test_bus != 8'h00) bad++;
    end
    chk("idle_quiet", bad, 0);

    // 2. D=6, byte A5
    clk_scaler = 8'd5; start = 1'b1;
    run_frame("f_a5", 6, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("f_a5_val", just_test_bus, bus_of(8'hA5));

    // 3. D=1, byte 3C
    clk_scaler = 8'd0; start = 1'b1;
    run_frame("f_3c", 1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("f_3c_val", just_test_bus, bus_of(8'h3C));

    // 4. Mid-frame start pulse and clk_scaler change must not disturb the frame
    clk_scaler = 8'd5; start = 1'b1;
    run_frame("f_dist", 6, 8'h96, 1'b0, 1'b1, 1'b0);
    chk("f_dist_val", just_test_bus, bus_of(8'h96));
    bad = 0;
    repeat (30) begin @(negedge clk); if (!cs_n || just_test) bad++; end
    chk("f_dist_noretrig", bad, 0);

    // 5. Reset during SHIFT aborts the frame with no strobe
    clk_scaler = 8'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_in_frame", cs_n, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cs_n", cs_n, 1'b1);
    chk("abort_sclk", sclk_n, 1'b1);
    chk("abort_bus",  just_test_bus, 8'h00);
    chk("abort_jt",   just_test, 1'b0);
    bad = 0;
    repeat (120) begin @(negedge clk); if (just_test || !cs_n) bad++; end
    chk("abort_quiet", bad, 0);
    start = 1'b1;
    run_frame("f_post", 6, 8'h5A, 1'b0, 1'b0, 1'b1);
    chk("f_post_val", just_test_bus, bus_of(8'h5A));

    // D = 2^W boundary
    clk_scaler = 8'hFF; start = 1'b1;
    tx = 8'($urandom);
    run_frame("f_max", 256, tx, 1'b0, 1'b0, 1'b1);
    chk("f_max_val", just_test_bus, bus_of(tx));

    // 6. start held high: back-to-back frames with random data and divider.
    // Between frames there is one DONE cycle and one IDLE cycle; each frame
    // checks that its accept edge comes right after that gap.
    ns = 6;
    start = 1'b1;
    for (int f = 0; f < ns; f++) begin
      clk_scaler = 8'($urandom_range(0, 7));
      d = int'(clk_scaler) + 1;
      tx = 8'($urandom);
      run_frame($sformatf("b2b%0d", f), d, tx, (f != ns-1), 1'b0, 1'b1);
      chk($sformatf("b2b%0d_tx", f), last_rx, tx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
